// File: rtl/irq_dispatch_scheduler.sv
// Interrupt dispatch scheduler: arbitrates enabled pending lines onto the core's single
// request/ID interface and claims the acknowledged line with a one-cycle pulse.
module irq_dispatch_scheduler #(
  parameter int NUM_IRQ     = 32,
  parameter int ID_WIDTH    = 5,
  parameter int ACK_TIMEOUT = 255,
  parameter int HOLDOFF     = 2
) (
  input  logic                clk_i,
  input  logic                HRESETn,
  input  logic [NUM_IRQ-1:0]  irq_pending_i,
  input  logic [NUM_IRQ-1:0]  irq_enable_i,
  input  logic                rr_en_i,
  output logic                core_irq_req_o,
  output logic [ID_WIDTH-1:0] core_irq_id_o,
  input  logic                core_irq_ack_i,
  output logic [NUM_IRQ-1:0]  irq_claim_o,
  output logic                timeout_o,
  output logic                busy_o
);

  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);
  localparam int SUM_W  = ID_WIDTH + 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [ID_WIDTH-1:0] ID_LAST   = ID_WIDTH'(NUM_IRQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                req_q, req_d;
  logic [NUM_IRQ-1:0]  claim_q, claim_d;
  logic                timeout_q, timeout_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   onehot_id;
  logic                 id_eligible;
  logic [ID_WIDTH-1:0]  start;
  logic [2*NUM_IRQ-1:0] elig2;
  logic [NUM_IRQ-1:0]   rotated;
  logic [SUM_W-1:0]     sum;
  logic [ID_WIDTH-1:0]  winner;
  logic                 found;
  logic [ID_WIDTH-1:0]  ptr_next;

  assign eligible    = irq_pending_i & irq_enable_i;
  assign onehot_id   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
  assign id_eligible = |(eligible & onehot_id);
  assign start       = rr_en_i ? ptr_q : '0;
  assign ptr_next    = (id_q == ID_LAST) ? '0 : id_q + 1'b1;

  // Rotate eligible so the search origin sits at bit 0, take the lowest set bit, then unrotate.
  always_comb begin
    elig2   = {eligible, eligible};
    rotated = NUM_IRQ'(elig2 >> start);
    sum     = '0;
    winner  = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = {1'b0, start} + SUM_W'(i);
        if (sum >= SUM_W'(NUM_IRQ)) sum = sum - SUM_W'(NUM_IRQ);
        winner = sum[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    req_d     = req_q;
    claim_d   = '0;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          id_d    = winner;
          req_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (core_irq_ack_i) begin
          req_d   = 1'b0;
          claim_d = onehot_id;
          ptr_d   = ptr_next;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else if (!id_eligible) begin
          req_d   = 1'b0;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else if (ACK_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          // Pointer moves past a timed-out line so it cannot starve the others.
          req_d     = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = ptr_next;
          hold_d    = '0;
          state_d   = ST_HOLD;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_IDLE;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      req_q     <= 1'b0;
      claim_q   <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      wait_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      req_q     <= req_d;
      claim_q   <= claim_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
    end
  end

  assign core_irq_req_o = req_q;
  assign core_irq_id_o  = id_q;
  assign irq_claim_o    = claim_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_irq_dispatch_scheduler.sv
// Bench for irq_dispatch_scheduler: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_irq_dispatch_scheduler;
  localparam int N  = 32;
  localparam int IW = 5;
  localparam int TO = 4;
  localparam int HO = 2;

  logic          clk_i = 1'b0;
  logic          HRESETn = 1'b0;
  logic [N-1:0]  irq_pending_i = '0;
  logic [N-1:0]  irq_enable_i = '0;
  logic          rr_en_i = 1'b0;
  logic          core_irq_ack_i = 1'b0;
  logic          core_irq_req_o;
  logic [IW-1:0] core_irq_id_o;
  logic [N-1:0]  irq_claim_o;
  logic          timeout_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [IW-1:0] exp_q[$];

  irq_dispatch_scheduler #(.NUM_IRQ(N), .ID_WIDTH(IW), .ACK_TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk_i(clk_i), .HRESETn(HRESETn), .irq_pending_i(irq_pending_i), .irq_enable_i(irq_enable_i),
    .rr_en_i(rr_en_i), .core_irq_req_o(core_irq_req_o), .core_irq_id_o(core_irq_id_o),
    .core_irq_ack_i(core_irq_ack_i), .irq_claim_o(irq_claim_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; irq_pending_i = '0; irq_enable_i = '1; rr_en_i = 1'b0; core_irq_ack_i = 1'b0;
    step(); step();
    HRESETn = 1'b1;
    model_ptr = 0;
    exp_q.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (core_irq_req_o) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Reference: first eligible line searching upward (with wrap) from the origin.
  function automatic int pick(logic [N-1:0] elig, int ptr, bit rr);
    int s;
    s = rr ? ptr : 0;
    for (int i = 0; i < N; i++) if (elig[(s + i) % N]) return (s + i) % N;
    return -1;
  endfunction

  task automatic test_reset();
    HRESETn = 1'b0; irq_pending_i = '1; irq_enable_i = '1; core_irq_ack_i = 1'b1;
    step(); step();
    checks++; if (core_irq_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", core_irq_req_o); end
    checks++; if (core_irq_id_o !== '0) begin errors++; $display("FAIL reset_id: got %0d exp 0", core_irq_id_o); end
    checks++; if (irq_claim_o !== '0) begin errors++; $display("FAIL reset_claim: got %h exp 0", irq_claim_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    core_irq_ack_i = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    irq_pending_i = 32'h0000_0014;
    checks++; if (core_irq_req_o !== 1'b0) begin errors++; $display("FAIL fixed_early_req: got %b exp 0", core_irq_req_o); end
    step();
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd2) begin errors++; $display("FAIL fixed_req1: got req=%b id=%0d exp req=1 id=2", core_irq_req_o, core_irq_id_o); end
    core_irq_ack_i = 1'b1;
    step();
    checks++; if (irq_claim_o !== 32'h4 || core_irq_req_o !== 1'b0) begin errors++; $display("FAIL fixed_claim1: got claim=%h req=%b exp claim=4 req=0", irq_claim_o, core_irq_req_o); end
    core_irq_ack_i = 1'b0; irq_pending_i = 32'h10;
    step();
    checks++; if (irq_claim_o !== '0) begin errors++; $display("FAIL fixed_claim_width: got %h exp 0", irq_claim_o); end
    step();
    checks++; if (core_irq_req_o !== 1'b0) begin errors++; $display("FAIL fixed_holdoff: got req=%b exp 0", core_irq_req_o); end
    step();
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd4) begin errors++; $display("FAIL fixed_req2: got req=%b id=%0d exp req=1 id=4", core_irq_req_o, core_irq_id_o); end
    core_irq_ack_i = 1'b1; irq_pending_i = '0;
    step();
    checks++; if (irq_claim_o !== 32'h10) begin errors++; $display("FAIL fixed_claim2: got %h exp 10", irq_claim_o); end
    core_irq_ack_i = 1'b0;
    step(); step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fixed_idle: got busy=%b exp 0", busy_o); end
  endtask

  task automatic test_rr_fairness();
    int exp_ids[6] = '{0, 1, 31, 0, 1, 31};
    logic [N-1:0] oh;
    bit ok;
    do_reset();
    rr_en_i = 1'b1; irq_pending_i = 32'h8000_0003;
    for (int k = 0; k < 6; k++) begin
      wait_req(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_req_timeout[%0d]: got no req exp req", k); end
      checks++; if (core_irq_id_o !== IW'(exp_ids[k])) begin errors++; $display("FAIL rr_id[%0d]: got %0d exp %0d", k, core_irq_id_o, exp_ids[k]); end
      core_irq_ack_i = 1'b1;
      step();
      oh = '0; oh[exp_ids[k]] = 1'b1;
      checks++; if (irq_claim_o !== oh) begin errors++; $display("FAIL rr_claim[%0d]: got %h exp %h", k, irq_claim_o, oh); end
      core_irq_ack_i = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int hi, gap, pulses;
    logic [N-1:0] claims;
    do_reset();
    irq_pending_i = 32'h1;
    step();
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd0) begin errors++; $display("FAIL to_req: got req=%b id=%0d exp req=1 id=0", core_irq_req_o, core_irq_id_o); end
    hi = 0; gap = 0; pulses = 0; claims = '0;
    for (int i = 0; i < 20 && core_irq_req_o; i++) begin hi++; step(); pulses += int'(timeout_o); claims |= irq_claim_o; end
    for (int i = 0; i < 20 && !core_irq_req_o; i++) begin gap++; step(); pulses += int'(timeout_o); claims |= irq_claim_o; end
    checks++; if (hi !== TO) begin errors++; $display("FAIL to_req_cycles: got %0d exp %0d", hi, TO); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses: got %0d exp 1", pulses); end
    checks++; if (claims !== '0) begin errors++; $display("FAIL to_claim: got %h exp 0", claims); end
    checks++; if (gap !== HO + 1) begin errors++; $display("FAIL to_gap: got %0d exp %0d", gap, HO + 1); end
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd0) begin errors++; $display("FAIL to_rereq: got req=%b id=%0d exp req=1 id=0", core_irq_req_o, core_irq_id_o); end
  endtask

  task automatic test_withdraw();
    do_reset();
    irq_pending_i = 32'h20;
    step();
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd5) begin errors++; $display("FAIL wd_req: got req=%b id=%0d exp req=1 id=5", core_irq_req_o, core_irq_id_o); end
    irq_enable_i[5] = 1'b0;
    step();
    checks++; if (core_irq_req_o !== 1'b0 || irq_claim_o !== '0 || timeout_o !== 1'b0) begin errors++; $display("FAIL wd_drop: got req=%b claim=%h to=%b exp 0/0/0", core_irq_req_o, irq_claim_o, timeout_o); end
    step();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wd_busy_hold: got %b exp 1", busy_o); end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wd_busy_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    irq_pending_i = 32'h1;
    step();
    step(); step(); step();
    core_irq_ack_i = 1'b1; irq_pending_i = '0;
    step();
    checks++; if (irq_claim_o !== 32'h1 || timeout_o !== 1'b0 || core_irq_req_o !== 1'b0) begin errors++; $display("FAIL simul_ack: got claim=%h to=%b req=%b exp 1/0/0", irq_claim_o, timeout_o, core_irq_req_o); end
    core_irq_ack_i = 1'b0;
    step();
    checks++; if (irq_claim_o !== '0 || timeout_o !== 1'b0) begin errors++; $display("FAIL simul_after: got claim=%h to=%b exp 0/0", irq_claim_o, timeout_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rr_en_i = 1'b1; irq_pending_i = 32'h4;
    step();
    core_irq_ack_i = 1'b1; step(); core_irq_ack_i = 1'b0;
    irq_pending_i = 32'h10;
    wait_req(ok);
    checks++; if (ok !== 1'b1 || core_irq_id_o !== 5'd4) begin errors++; $display("FAIL rst_pre_id: got ok=%b id=%0d exp 1/4", ok, core_irq_id_o); end
    HRESETn = 1'b0;
    #1;
    checks++; if (core_irq_req_o !== 1'b0 || irq_claim_o !== '0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_async: got req=%b claim=%h busy=%b to=%b exp all 0", core_irq_req_o, irq_claim_o, busy_o, timeout_o); end
    irq_pending_i = 32'h11;
    step();
    HRESETn = 1'b1;
    step();
    checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== 5'd0) begin errors++; $display("FAIL rst_ptr: got req=%b id=%0d exp req=1 id=0", core_irq_req_o, core_irq_id_o); end
  endtask

  task automatic test_random();
    logic [N-1:0] pend, en, oh;
    logic [IW-1:0] exp_id;
    int e, action, d, b;
    bit rr;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      pend = $urandom; en = $urandom; rr = 1'($urandom_range(0, 1));
      if ((pend & en) == '0) begin b = $urandom_range(0, N - 1); pend[b] = 1'b1; en[b] = 1'b1; end
      irq_pending_i = pend; irq_enable_i = en; rr_en_i = rr;
      e = pick(pend & en, model_ptr, rr);
      exp_q.push_back(IW'(e));
      step();
      exp_id = exp_q.pop_front();
      checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== exp_id) begin errors++; $display("FAIL rand_req[%0d]: got req=%b id=%0d exp req=1 id=%0d", t, core_irq_req_o, core_irq_id_o, exp_id); end
      oh = '0; oh[exp_id] = 1'b1;
      action = $urandom_range(0, 2);
      d = (action == 2) ? TO - 1 : $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        irq_pending_i = $urandom | oh; irq_enable_i = $urandom | oh;
        step();
        checks++; if (core_irq_req_o !== 1'b1 || core_irq_id_o !== exp_id) begin errors++; $display("FAIL rand_hold_req[%0d]: got req=%b id=%0d exp req=1 id=%0d", t, core_irq_req_o, core_irq_id_o, exp_id); end
      end
      if (action == 0) core_irq_ack_i = 1'b1;
      else if (action == 1) begin
        if ($urandom_range(0, 1) == 0) irq_enable_i[exp_id] = 1'b0;
        else irq_pending_i[exp_id] = 1'b0;
      end
      step();
      if (action == 0) begin
        checks++; if (irq_claim_o !== oh || timeout_o !== 1'b0) begin errors++; $display("FAIL rand_ack[%0d]: got claim=%h to=%b exp %h/0", t, irq_claim_o, timeout_o, oh); end
        model_ptr = (int'(exp_id) + 1) % N;
      end else if (action == 1) begin
        checks++; if (irq_claim_o !== '0 || timeout_o !== 1'b0 || core_irq_req_o !== 1'b0) begin errors++; $display("FAIL rand_drop[%0d]: got claim=%h to=%b req=%b exp 0/0/0", t, irq_claim_o, timeout_o, core_irq_req_o); end
      end else begin
        checks++; if (irq_claim_o !== '0 || timeout_o !== 1'b1 || core_irq_req_o !== 1'b0) begin errors++; $display("FAIL rand_to[%0d]: got claim=%h to=%b req=%b exp 0/1/0", t, irq_claim_o, timeout_o, core_irq_req_o); end
        model_ptr = (int'(exp_id) + 1) % N;
      end
      core_irq_ack_i = 1'b0; irq_pending_i = '0;
      b = 0;
      for (int k = 0; k < 10 && busy_o; k++) begin b++; step(); end
      checks++; if (b !== HO) begin errors++; $display("FAIL rand_hold_len[%0d]: got %0d exp %0d", t, b, HO); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_timeout();
    test_withdraw();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_dispatch_scheduler.md
Name: irq_dispatch_scheduler

Overview:
- Sits between the interrupt service unit's pending vector and the core's single-request interrupt interface.
- Selects one enabled pending line, using either fixed-priority or round-robin arbitration.
- Presents the selected line to the core as a request/ID pair and waits for acknowledge.
- On acknowledge, issues a one-cycle claim pulse that clears the line in the service unit.
- Stalled requests are withdrawn on timeout, or when the line drops, so a dead request never blocks the other lines.

Parameters:
- NUM_IRQ, 32: number of interrupt lines. Allowed range 2..32.
- ID_WIDTH, 5: width of the line ID. Must satisfy ID_WIDTH = clog2(NUM_IRQ).
- ACK_TIMEOUT, 255: cycles in REQ before the request is withdrawn. 0 disables the timeout.
- HOLDOFF, 2: cycles spent in HOLD between two requests. Must be at least 1.

Ports:
- clk_i  in  1  clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- irq_pending_i  in  NUM_IRQ  pending vector from the service unit.
- irq_enable_i  in  NUM_IRQ  per-line enable. 1 = the line is eligible.
- rr_en_i  in  1  arbitration mode. 1 = round-robin, 0 = fixed priority with index 0 highest.
- core_irq_req_o  out  1  interrupt request to the core.
- core_irq_id_o  out  ID_WIDTH  ID of the requested line.
- core_irq_ack_i  in  1  core acknowledge. Meaningful only while core_irq_req_o=1.
- irq_claim_o  out  NUM_IRQ  one-hot pulse that clears the claimed line.
- timeout_o  out  1  one-cycle pulse when a request is withdrawn by timeout.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, wait counter 0, hold counter 0.
- Eligible vector: eligible = irq_pending_i & irq_enable_i.
- Fixed-priority arbitration: the winner is the lowest set index in eligible.
- Round-robin arbitration: the winner is the first set index found searching upward from the rr pointer, wrapping from NUM_IRQ-1 to 0.
- Arbitration is combinational and is evaluated only in IDLE.
- A change on rr_en_i takes effect at the next IDLE evaluation.

States:
- IDLE. If eligible is nonzero at a clock edge:
  - id_q <= winner, core_irq_req_o <= 1, wait counter <= 0, next state REQ.
  - Latency: req is visible 1 cycle after eligible is sampled nonzero.
- REQ. core_irq_req_o and core_irq_id_o are held stable. Conditions are evaluated in priority order:
  1. core_irq_ack_i=1 → req <= 0, irq_claim_o <= onehot(id_q) for exactly one cycle, rr pointer <= (id_q+1) mod NUM_IRQ, next state HOLD. Ack wins over every other condition in the same cycle.
  2. eligible[id_q]=0 (line cleared or disabled) → req <= 0, no claim, rr pointer unchanged, next state HOLD.
  3. ACK_TIMEOUT≠0 and wait counter = ACK_TIMEOUT-1 → req <= 0, timeout_o pulses for one cycle, rr pointer <= (id_q+1) mod NUM_IRQ, next state HOLD. The pointer advances even in fixed-priority mode, since the pointer is ignored there.
  4. Otherwise → wait counter increments. The counter saturates and never wraps.
- HOLD. Stays for exactly HOLDOFF cycles, counted from the first HOLD cycle, then goes to IDLE.
  - The claim or timeout pulse coincides with the first HOLD cycle.
  - Pending inputs are ignored during HOLD. This gives the service unit time to clear the claimed line before the next arbitration.

Boundary and ordering rules:
- A line that rises during REQ or HOLD is considered at the next IDLE evaluation.
- At most one claim bit is ever set, and claim never asserts outside the first HOLD cycle.
- When the rr pointer is at NUM_IRQ-1 and eligible contains bits 0 and NUM_IRQ-1, the winner is NUM_IRQ-1. When eligible contains only bit 0, the winner is 0.
- An ack received while req=0 is ignored.
- HRESETn asserted mid-request drops req immediately, with no claim, and returns to reset values.
- core_irq_id_o keeps its last value while req=0. Its value is only meaningful while req=1.

Test Plan:
- Fixed priority: rr_en=0, enable all, pending=0x0000_0014 → req=1 with id=2 one cycle later. Ack → claim=0x0000_0004 for 1 cycle. Pending is then cleared to 0x10 → next req has id=4 after HOLDOFF+1 cycles.
- Round-robin fairness: rr_en=1, pending held at 0x8000_0003, core acks every request → ids come out as 0, 1, 31, 0, 1, 31…
- Timeout: ACK_TIMEOUT=4, pending=0x1, no ack → req high for exactly 4 cycles, timeout_o pulses once, claim stays 0, then id=0 is re-requested after the HOLD period.
- Withdraw: pending=0x20, req id=5 active. Clear irq_enable_i[5] → req drops on the next edge, claim and timeout stay 0, busy returns to 0 after HOLDOFF cycles.
- Simultaneous events: ack in the same cycle that pending[id] falls and the timeout expires → claim pulses, timeout_o stays 0.
- Reset mid-REQ: assert HRESETn low while req=1 → req, claim, busy and timeout go to 0 immediately. After release with pending=0x1, id=0 is requested with the rr pointer at 0.
